// File: rtl/bus_pkg.sv
// Shared definitions for the 6-source bus arbiter.
// Contents: source count, select width, idle mux code, FSM state encoding,
// and a helper that turns a source index into its one-hot grant vector.
package bus_pkg;

    localparam int unsigned NUM_SRC = 6;
    localparam int unsigned SEL_W   = 3;
    localparam logic [2:0]  SEL_IDLE = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // One-hot grant vector for a source index (0..5).
    function automatic logic [5:0] src_onehot(input logic [2:0] idx);
        logic [5:0] one_v;
        one_v = 6'b000001;
        return one_v << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search for the bus arbiter.
// Ports:
//   req   [5:0] in  : request vector, bit i = source i
//   start [2:0] in  : first index examined (0..5); search proceeds upward and wraps 5->0
//   mask  [5:0] in  : sources excluded from this search
//   found       out : at least one unmasked requester exists
//   idx   [2:0] out : index of the first unmasked requester at or after start
module rr_pick
    import bus_pkg::*;
(
    input  logic [5:0] req,
    input  logic [2:0] start,
    input  logic [5:0] mask,
    output logic       found,
    output logic [2:0] idx
);

    logic [5:0] cand_s;

    // Modulo-6 add; operands stay below 13 so two conditional subtractions suffice.
    function automatic logic [2:0] wrap6(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum_v;
        sum_v = {1'b0, base} + {1'b0, off};
        if (sum_v >= 4'd6) begin
            sum_v = sum_v - 4'd6;
        end else begin
            sum_v = sum_v;
        end
        if (sum_v >= 4'd6) begin
            sum_v = sum_v - 4'd6;
        end else begin
            sum_v = sum_v;
        end
        return sum_v[2:0];
    endfunction

    assign cand_s = req & ~mask;

    // Walk the six positions from start; the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!found && cand_s[wrap6(start, 3'(i))]) begin
                found = 1'b1;
                idx   = wrap6(start, 3'(i));
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Six-source bus arbiter with registered grant / mux-select outputs.
// Optional build macro: BUS_ARB_FIXED_PRIO_EN selects fixed priority
// (source a highest) instead of round-robin; ports and timing are unchanged.
// Ports:
//   clk        in  : rising-edge clock
//   rst        in  : synchronous active-high reset
//   req   [5:0] in : per-source request (bit0=a .. bit5=f)
//   grant [5:0] out: one-hot grant, zero when idle
//   S0,S1,S2   out : bus mux select (S2 = MSB), 3'b111 when idle
//   bus_valid  out : bus carries the selected source's value
//   last_src [2:0] out: most recently granted source
// Parameter HOLD_CYCLES (1..15): cycles each grant drives the bus.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    output logic [5:0] grant,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic       bus_valid,
    output logic [2:0] last_src
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] last_q, last_d;
    logic [5:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic       valid_q, valid_d;

    logic [2:0] start_s;
    logic [5:0] mask_s;
    logic       found_s;
    logic [2:0] pick_s;
    logic       launch_s;
    logic [2:0] launch_idx_s;

    // Search origin and exclusion set for the winner search.
    always_comb begin
        start_s = 3'd0;
        mask_s  = 6'b000000;
`ifdef BUS_ARB_FIXED_PRIO_EN
        // Fixed priority always scans from a; the owner is not excluded so a
        // persistent higher-priority requester keeps the bus.
        start_s = 3'd0;
        mask_s  = 6'b000000;
`else
        if (last_q == 3'd5) begin
            start_s = 3'd0;
        end else begin
            start_s = last_q + 3'd1;
        end
        if (state_q == GRANT) begin
            mask_s = src_onehot(last_q);
        end else begin
            mask_s = 6'b000000;
        end
`endif
    end

    rr_pick u_pick (
        .req   (req),
        .start (start_s),
        .mask  (mask_s),
        .found (found_s),
        .idx   (pick_s)
    );

    // Decide whether a new grant starts this edge, and for whom.
    always_comb begin
        launch_s     = 1'b0;
        launch_idx_s = pick_s;
        case (state_q)
            IDLE: begin
                launch_s     = found_s;
                launch_idx_s = pick_s;
            end
            GRANT: begin
                if (cnt_q != 4'd0) begin
                    launch_s = 1'b0;
                end else if (found_s) begin
                    launch_s     = 1'b1;
                    launch_idx_s = pick_s;
                end else if (req[last_q]) begin
                    // Sole requester is the current owner: re-grant it back-to-back.
                    launch_s     = 1'b1;
                    launch_idx_s = last_q;
                end else begin
                    launch_s = 1'b0;
                end
            end
            default: begin
                launch_s = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (launch_s) begin
            state_d = GRANT;
            cnt_d   = HOLD_LOAD;
            last_d  = launch_idx_s;
            grant_d = src_onehot(launch_idx_s);
            sel_d   = launch_idx_s;
            valid_d = 1'b1;
        end else if ((state_q == GRANT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            grant_d = 6'b000000;
            sel_d   = SEL_IDLE;
            valid_d = 1'b0;
        end
    end

    // State and output registers; reset leaves last_q at 5 so source a wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 3'd5;
            grant_q <= 6'b000000;
            sel_q   <= SEL_IDLE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign grant     = grant_q;
    assign S0        = sel_q[0];
    assign S1        = sel_q[1];
    assign S2        = sel_q[2];
    assign bus_valid = valid_q;
    assign last_src  = last_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// requests/resets compared each cycle against a transaction-level model.
module tb_bus_arbiter;

    localparam int HOLD = 2;

    logic       clk;
    logic       rst;
    logic [5:0] req;
    logic [5:0] grant;
    logic       S0, S1, S2;
    logic       bus_valid;
    logic [2:0] last_src;

    int n_total = 0;
    int n_pass  = 0;

    // Model state: cycles of the current grant still to run (0 = idle).
    int m_rem   = 0;
    int m_owner = 0;
    int m_last  = 5;

    bus_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .S0        (S0),
        .S1        (S1),
        .S2        (S2),
        .bus_valid (bus_valid),
        .last_src  (last_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // First requester found scanning the sources in arbitration order, or -1.
    function automatic int model_pick(input logic [5:0] r, input int excl);
        int i;
        for (int k = 0; k < 6; k++) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
            i = k;
            if (r[i]) return i;
`else
            i = (m_last + 1 + k) % 6;
            if (r[i] && i != excl) return i;
`endif
        end
        return -1;
    endfunction

    task automatic model_step(input logic [5:0] r, input logic rs);
        int w;
        if (rs) begin
            m_rem  = 0;
            m_last = 5;
        end else if (m_rem > 1) begin
            m_rem = m_rem - 1;
        end else begin
            w = model_pick(r, (m_rem == 1) ? m_owner : -1);
            if (w < 0 && m_rem == 1 && r[m_owner]) w = m_owner;
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_rem   = HOLD;
            end else begin
                m_rem = 0;
            end
        end
    endtask

    task automatic compare_all();
        int e_sel;
        int e_grant;
        e_sel   = (m_rem > 0) ? m_owner : 7;
        e_grant = (m_rem > 0) ? (1 << m_owner) : 0;
        check_eq("sel", int'({S2, S1, S0}), e_sel);
        check_eq("grant", int'(grant), e_grant);
        check_eq("bus_valid", int'(bus_valid), (m_rem > 0) ? 1 : 0);
        check_eq("last_src", int'(last_src), m_last);
    endtask

    // One clock: drive at negedge, model the edge, sample 1 time unit later.
    task automatic cycle(input logic [5:0] r, input logic rs);
        @(negedge clk);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        compare_all();
    endtask

`ifndef BUS_ARB_FIXED_PRIO_EN
    int seq_all [14] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0, 0};
`endif

    initial begin
        req = 6'b000000;
        rst = 1'b1;
        cycle(6'b000000, 1'b1);
        cycle(6'b000000, 1'b1);

        // Idle with no requests.
        for (int i = 0; i < 5; i++) cycle(6'b000000, 1'b0);

        // Single one-cycle request from a.
        cycle(6'b000001, 1'b0);
        for (int i = 0; i < 4; i++) cycle(6'b000000, 1'b0);

        // All sources requesting: continuous rotation.
        cycle(6'b000000, 1'b1);
        for (int i = 0; i < 14; i++) begin
            cycle(6'b111111, 1'b0);
`ifndef BUS_ARB_FIXED_PRIO_EN
            check_eq("rr_seq", int'({S2, S1, S0}), seq_all[i]);
            check_eq("rr_valid", int'(bus_valid), 1);
`endif
        end

        // Owner f in its final cycle with a also requesting: wrap to a.
        cycle(6'b000000, 1'b1);
        cycle(6'b100000, 1'b0);
        cycle(6'b100001, 1'b0);
        cycle(6'b100001, 1'b0);
        check_eq("wrap_sel", int'({S2, S1, S0}), 0);
        cycle(6'b000000, 1'b0);
        cycle(6'b000000, 1'b0);

        // b and c held.
        for (int i = 0; i < 10; i++) cycle(6'b000110, 1'b0);
        for (int i = 0; i < 3; i++) cycle(6'b000000, 1'b0);

        // Reset in the first cycle of a grant to c.
        cycle(6'b000100, 1'b0);
        check_eq("c_grant", int'({S2, S1, S0}), 2);
        cycle(6'b000100, 1'b1);
        check_eq("rst_sel", int'({S2, S1, S0}), 7);
        cycle(6'b000100, 1'b0);
        check_eq("post_rst", int'({S2, S1, S0}), 2);
        for (int i = 0; i < 3; i++) cycle(6'b000000, 1'b0);

        // Randomized requests with occasional reset.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] r;
            r = 6'($urandom);
            if ($urandom_range(0, 3) == 0) r = 6'b000000;
            cycle(r, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL run on one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-002 Parameter HOLD_CYCLES, default 2, SHALL set the number of cycles each grant drives the bus (legal range 1..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req  input  6  request per bus source: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f.
REQ-006 grant  output  6  one-hot grant, all zero when idle.
REQ-007 S0, S1, S2  output  1 each  bus select (S2 is MSB), driven straight into the 6-to-1 bus mux.
REQ-008 bus_valid  output  1  high while the selected source's value on the bus is meaningful.
REQ-009 last_src  output  3  index of the most recently granted source.

Function
REQ-010 All outputs SHALL be registered, with no combinational path from req to any output.
REQ-011 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-012 In IDLE, the block SHALL sample req at each rising edge; if req is nonzero, it SHALL enter GRANT at that edge.
REQ-013 grant, {S2,S1,S0} and bus_valid SHALL therefore appear one cycle after the sampled req (latency 1).
REQ-014 Arbitration SHALL be round-robin: the winner is the first set req bit searching upward from last_src+1 modulo 6.
REQ-015 The search SHALL wrap from index 5 to index 0.
REQ-016 In GRANT, {S2,S1,S0} SHALL equal the winner index (0..5), grant SHALL be its one-hot bit, and bus_valid SHALL be 1.
REQ-017 A grant SHALL last exactly HOLD_CYCLES cycles, counted by a 4-bit down-counter loaded with HOLD_CYCLES-1.
REQ-018 Deasserting the owner's req mid-grant SHALL NOT shorten the grant.
REQ-019 In the final grant cycle (counter==0), the block SHALL re-arbitrate on the current req, masking out the current owner.
REQ-020 If that re-arbitration finds a requester, the next grant SHALL start on the very next cycle (no idle gap, back-to-back).
REQ-021 If it finds none, the block SHALL return to IDLE.
REQ-022 If the current owner is the only requester in the final cycle, it SHALL be re-granted back-to-back.
REQ-023 In IDLE, {S2,S1,S0} SHALL be 3'b111 (a don't-care mux code), grant SHALL be 0, and bus_valid SHALL be 0.
REQ-024 Select codes 6 and 7 SHALL never be driven while bus_valid=1.
REQ-025 last_src SHALL update at the start of each grant.

Reset
REQ-026 While rst is sampled high, the block SHALL hold: state=IDLE, grant=0, {S2,S1,S0}=3'b111, bus_valid=0, last_src=5 (so source a wins first), counter=0.
REQ-027 Reset asserted mid-grant SHALL abort the grant at that edge; arbitration resumes in the first cycle after rst falls.

Configuration
REQ-028 With macro BUS_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: lowest set index wins (a highest, f lowest), and last_src is ignored for selection.
REQ-029 Without BUS_ARB_FIXED_PRIO_EN, round-robin per REQ-014 SHALL apply.
REQ-030 Ports and timing SHALL be identical in both builds.

Structure
REQ-031 Shared package bus_pkg SHALL hold: NUM_SRC=6, SEL_W=3, SEL_IDLE=3'b111, and the state encoding (IDLE, GRANT).
REQ-032 Winner selection SHALL live in one combinational sub-module, rr_pick, with inputs req[5:0], start[2:0] and mask[5:0], and outputs found and idx[2:0].
REQ-033 Under BUS_ARB_FIXED_PRIO_EN, the arbiter SHALL tie start to 0 when instantiating rr_pick.

Verification
REQ-034 Reset, then req=6'b000000 for 5 cycles -> grant=0, sel=3'b111 and bus_valid=0 throughout.
REQ-035 req=6'b000001 (a) for 1 cycle with HOLD_CYCLES=2 -> next cycle sel=0, grant=6'b000001, bus_valid=1 for exactly 2 cycles, then IDLE.
REQ-036 req=6'b111111 held with HOLD_CYCLES=2 -> sel sequence 0,0,1,1,2,2,3,3,4,4,5,5,0,0 with no gap and bus_valid continuously 1.
REQ-037 Owner f (sel=5) in its final cycle while req=6'b100001 -> next grant sel=0 (wrap); with BUS_ARB_FIXED_PRIO_EN the result is also sel=0.
REQ-038 req=6'b000110 held, BUS_ARB_FIXED_PRIO_EN defined -> sel stays 1 on every grant; undefined -> sel alternates 1,2.
REQ-039 rst asserted in the first cycle of a grant to c -> the next cycle shows sel=3'b111 and bus_valid=0; after rst falls with req=6'b000100, c is granted one cycle later.
